// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//   Parametrised, double-buffered UART transmitter. A one-entry holding
//   register lets the producer queue the next word while the current frame
//   shifts out, so consecutive frames leave with no idle gap.
//
// Parameters
//   DATA_BITS    : data bits per frame (5..9), sent LSB first
//   PARITY_MODE  : 0 = none, 1 = even, 2 = odd
//   STOP_BITS    : stop bits per frame (1 or 2)
//   CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   tx_enable  : 0 blocks new frames; a frame in flight completes
//   data_valid : producer offers data_in this cycle
//   data_in    : word to transmit
//   tx_ready   : holding register empty (transfer on data_valid & tx_ready)
//   serial_out : line output, idles high
//   busy       : high while a frame is on the line
//   tx_done    : one-cycle pulse in the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 data_valid,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 tx_done
);

    // Reject illegal configurations at elaboration time.
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be in 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
            $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic              HAS_PARITY = (PARITY_MODE != 0);
    localparam logic              ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [BAUD_W-1:0]    baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic [DATA_BITS-1:0] hold_data_reg, hold_data_next;
    logic                 hold_full_reg, hold_full_next;

    logic                 accept;
    logic                 bit_end;
    logic                 launch_hold;
    logic                 launch_direct;
    logic [DATA_BITS-1:0] load_data;

    assign accept    = data_valid && !hold_full_reg;
    assign bit_end   = (baud_cnt_reg == BAUD_LAST);
    // A queued word always has priority over the input port; the two can
    // never launch together because accept requires an empty holding register.
    assign load_data = launch_hold ? hold_data_reg : data_in;

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        hold_data_next = hold_data_reg;
        hold_full_next = hold_full_reg;
        launch_hold    = 1'b0;
        launch_direct  = 1'b0;
        serial_out     = 1'b1;
        tx_done        = 1'b0;

        // Baud counter free-runs inside a frame and wraps at every bit boundary.
        if (state_reg != ST_IDLE) begin
            baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (tx_enable && hold_full_reg) begin
                    launch_hold = 1'b1;
                end else if (tx_enable && accept) begin
                    launch_direct = 1'b1;
                end
            end
            ST_START: begin
                serial_out = 1'b0;
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                serial_out = shift_reg[0];
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                serial_out = parity_reg;
                if (bit_end) begin
                    state_next   = ST_STOP;
                    bit_cnt_next = '0;
                end
            end
            ST_STOP: begin
                serial_out = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        tx_done = 1'b1;
                        if (tx_enable && hold_full_reg) begin
                            launch_hold = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Anything accepted that is not launched straight from IDLE is parked
        // in the holding register, including a word arriving on the edge
        // where STOP decides to return to IDLE.
        if (accept && !launch_direct) begin
            hold_data_next = data_in;
            hold_full_next = 1'b1;
        end

        if (launch_hold) begin
            hold_full_next = 1'b0;
        end

        // Parity is frozen at load time so the shift register can be consumed.
        if (launch_hold || launch_direct) begin
            shift_next    = load_data;
            parity_next   = (^load_data) ^ ODD_PARITY;
            state_next    = ST_START;
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            hold_data_reg <= hold_data_next;
            hold_full_reg <= hold_full_next;
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign tx_ready = !hold_full_reg;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised, double-buffered UART transmitter for the router's serial link. It is the successor to the fixed 8-bit start/data/stop transmitter. It adds configurable data width, parity mode, stop-bit count and baud divider, plus a one-entry holding register with a valid/ready handshake. With the holding register, a new byte can be queued while the current frame shifts out, so frames go back-to-back with no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
tx_enable  input  1  when 0, no new frame starts; a frame in flight completes.
data_valid  input  1  producer offers data_in this cycle.
data_in  input  DATA_BITS  byte to transmit.
tx_ready  output  1  holding register empty; a transfer occurs when data_valid & tx_ready.
serial_out  output  1  line output; idles high.
busy  output  1  high while a frame is on the line (START through the last STOP cycle).
tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (reset == 0, asynchronous):
  - State = IDLE; baud counter, bit counter, shift register and holding register are cleared; holding register is empty.
  - Outputs: serial_out = 1, busy = 0, tx_ready = 1, tx_done = 0.
  - Reset mid-frame aborts the frame immediately; serial_out returns high with no partial stop bit.
- Handshake:
  - A byte is accepted on a clock edge where data_valid = 1 and tx_ready = 1.
  - data_in is sampled only on that edge.
  - tx_ready is registered and equals "holding register empty".
- Acceptance routing:
  - In IDLE with tx_enable = 1 and the holding register empty, an accepted byte loads the shift register directly and the FSM enters START. serial_out = 0 from the next cycle (1-cycle latency). The holding register stays empty and tx_ready stays 1.
  - In any other case, an accepted byte goes into the holding register and tx_ready drops to 0 on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and reloads 0 at every bit boundary.
- START: serial_out = 0 for one bit time, then go to DATA.
- DATA:
  - serial_out = shift register [0]; the register shifts right at each bit end.
  - After DATA_BITS bits, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Parity is computed from the byte at load time.
  - Even mode: bit = XOR of the data bits. Odd mode: bit = its inverse.
  - Go to STOP after one bit time.
- STOP:
  - serial_out = 1 for STOP_BITS bit times.
  - tx_done = 1 in the last cycle of the last stop bit.
- End of STOP:
  - If the holding register is full and tx_enable = 1, transfer it to the shift register, mark the holding register empty (tx_ready = 1 next cycle) and go to START. The next frame's start bit begins on the following cycle (zero idle cycles).
  - Otherwise go to IDLE.
- Simultaneous events: if a byte is accepted on the same edge that the STOP→IDLE decision is made, it goes into the holding register. It is then launched from IDLE on the next cycle (1 idle cycle).
- tx_enable = 0:
  - IDLE is held even when the holding register is full, so tx_ready stays 0 and backpressures the producer.
  - Frames resume on the first cycle tx_enable returns to 1.
- busy = 0 only in IDLE.
- Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Illegal parameter values are a compile-time error.

Test Plan:
1. Defaults except CLKS_PER_BIT = 4. Send 0xA5 → line reads 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles. tx_done pulses at cycle 40 after the start bit begins. busy is high for 40 cycles.
2. PARITY_MODE = 1, then = 2, with 0xA5 (four 1s) → parity bit 0 (even) and 1 (odd). Frame = 44 cycles.
3. DATA_BITS = 5, STOP_BITS = 2, CLKS_PER_BIT = 2, send 0x13 → 0, 1,1,0,0,1, 1,1. 16 cycles total.
4. Back-to-back: send 0x55, then 0x0F two cycles later.
   - tx_ready drops after the second accept.
   - The 0x0F start bit follows the 0x55 stop bit with no high gap.
   - tx_ready returns to 1 on the transfer.
   - A third byte offered while tx_ready = 0 is not accepted until then.
5. Reset = 0 asserted mid-DATA → serial_out = 1 and busy = 0 immediately, with no clock edge needed. tx_ready = 1. After release, a new byte transmits correctly.
6. tx_enable = 0 with 0x3C accepted → stays IDLE, serial_out = 1, tx_ready = 0. A second data_valid is refused. Raising tx_enable → start bit the next cycle, then 0x3C sent.
